// File: rtl/cfg_reg_arbiter_if.sv
// cfg_reg_arbiter_if -- write-request bus shared by the two requesters of
// cfg_reg_arbiter.
//
// Requester A (SPI peripheral) and requester B (on-chip sequencer) each have
// a valid/ready handshake that carries a 7-bit register address and an
// 8-bit write value. A write is accepted on the clock edge where valid and
// ready are both high.
//
// Signals:
//   a_valid, b_valid  requester -> arbiter  write request
//   a_addr,  b_addr   requester -> arbiter  target register address (7 bits)
//   a_data,  b_data   requester -> arbiter  write value (8 bits)
//   a_ready, b_ready  arbiter -> requester  grant
//
// Modports:
//   master  requester side (drives valid/addr/data, observes ready)
//   slave   arbiter side   (observes valid/addr/data, drives ready)
interface cfg_reg_arbiter_if;
  logic       a_valid;
  logic [6:0] a_addr;
  logic [7:0] a_data;
  logic       a_ready;

  logic       b_valid;
  logic [6:0] b_addr;
  logic [7:0] b_data;
  logic       b_ready;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/cfg_reg_arbiter.sv
// cfg_reg_arbiter -- two-requester round-robin arbiter in front of a small
// bank of configuration registers.
//
// Each accepted write is captured into a one-entry commit stage and applied
// to its target register on the following edge, which gives a sustained
// throughput of one write per cycle. Addresses 0x00-0x04 map to the five
// config outputs. Any higher address sets the sticky bad_addr_err flag and
// the data is dropped.
//
// Optional feature, selected by the macro CFG_SHADOW_EN:
//   defined   - commits go to five shadow registers. The outputs load all of
//               the shadows on an edge where apply=1, and a commit on that
//               same edge is forwarded straight through.
//   undefined - commits write the outputs directly, and apply is ignored.
//
// Ports:
//   clk              system clock, all state on the rising edge
//   rst_n            asynchronous active-low reset
//   bus              cfg_reg_arbiter_if.slave, requester A/B handshakes
//   apply            shadow-to-output transfer strobe
//   err_clr          clears bad_addr_err
//   en_reg_out_7_0   config register at address 0x00
//   en_reg_out_15_8  config register at address 0x01
//   en_reg_pwm_7_0   config register at address 0x02
//   en_reg_pwm_15_8  config register at address 0x03
//   pwm_duty_cycle   config register at address 0x04
//   bad_addr_err     sticky flag, set when a write to an address above 0x04 commits
//   wr_count         count of committed valid-address writes (wraps)
module cfg_reg_arbiter (
  input  logic                clk,
  input  logic                rst_n,
  cfg_reg_arbiter_if.slave    bus,
  input  logic                apply,
  input  logic                err_clr,
  output logic [7:0]          en_reg_out_7_0,
  output logic [7:0]          en_reg_out_15_8,
  output logic [7:0]          en_reg_pwm_7_0,
  output logic [7:0]          en_reg_pwm_15_8,
  output logic [7:0]          pwm_duty_cycle,
  output logic                bad_addr_err,
  output logic [7:0]          wr_count
);

  localparam int         NUM_REGS  = 5;
  localparam logic [6:0] LAST_ADDR = 7'h04;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  grant_t     last_grant;
  logic       a_grant;
  logic       b_grant;

  logic       cm_valid;
  logic [6:0] cm_addr;
  logic [7:0] cm_data;
  logic       cm_hit;
  logic       cm_bad;

  logic [7:0] cfg_q   [NUM_REGS];
  logic [7:0] store_q [NUM_REGS];
  logic [7:0] store_d [NUM_REGS];

  // Grants are purely combinational. When both requesters are valid, the one
  // that did not win last time is granted. Gating with rst_n keeps both
  // readies low during reset.
  always_comb begin
    a_grant = rst_n && bus.a_valid && (!bus.b_valid || (last_grant == GRANT_B));
    b_grant = rst_n && bus.b_valid && (!bus.a_valid || (last_grant == GRANT_A));
  end

  assign bus.a_ready = a_grant;
  assign bus.b_ready = b_grant;

  // last_grant moves only when a write is actually accepted. Reset leaves it
  // at B, so A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_B;
    end else if (a_grant) begin
      last_grant <= GRANT_A;
    end else if (b_grant) begin
      last_grant <= GRANT_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_valid <= 1'b0;
      cm_addr  <= 7'h00;
      cm_data  <= 8'h00;
    end else begin
      cm_valid <= a_grant || b_grant;
      if (a_grant) begin
        cm_addr <= bus.a_addr;
        cm_data <= bus.a_data;
      end else if (b_grant) begin
        cm_addr <= bus.b_addr;
        cm_data <= bus.b_data;
      end
    end
  end

  assign cm_hit = cm_valid && (cm_addr <= LAST_ADDR);
  assign cm_bad = cm_valid && (cm_addr >  LAST_ADDR);

  // store_q is whichever bank receives commits: the shadows, or the outputs
  // themselves when there is no shadow stage. store_d is that bank with the
  // pending commit merged in.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      store_d[i] = (cm_hit && (cm_addr == 7'(i))) ? cm_data : store_q[i];
    end
  end

`ifdef CFG_SHADOW_EN
  logic [7:0] shadow_q [NUM_REGS];

  assign store_q = shadow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      shadow_q <= store_d;
    end
  end

  // Loading from store_d rather than shadow_q forwards a commit on the same
  // edge as apply straight to the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cfg_q[i] <= 8'h00;
      end
    end else if (apply) begin
      cfg_q <= store_d;
    end
  end
`else
  logic apply_unused;

  assign apply_unused = apply;
  assign store_q      = cfg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cfg_q[i] <= 8'h00;
      end
    end else begin
      cfg_q <= store_d;
    end
  end
`endif

  // If a bad write commits on the same edge as err_clr, the set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_addr_err <= 1'b0;
    end else if (cm_bad) begin
      bad_addr_err <= 1'b1;
    end else if (err_clr) begin
      bad_addr_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= 8'h00;
    end else if (cm_hit) begin
      wr_count <= wr_count + 8'd1;
    end
  end

  assign en_reg_out_7_0  = cfg_q[0];
  assign en_reg_out_15_8 = cfg_q[1];
  assign en_reg_pwm_7_0  = cfg_q[2];
  assign en_reg_pwm_15_8 = cfg_q[3];
  assign pwm_duty_cycle  = cfg_q[4];

endmodule

// File: doc/cfg_reg_arbiter.md
CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

Interface
REQ-001 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports a_valid/b_valid  input  1  write request from requester A (SPI peripheral) / B (on-chip sequencer).
REQ-004 SHALL have ports a_addr/b_addr  input  7  target register address.
REQ-005 SHALL have ports a_data/b_data  input  8  write value.
REQ-006 SHALL have ports a_ready/b_ready  output  1  grant; write accepted on the edge where valid and ready are both 1.
REQ-007 SHALL have port apply  input  1  shadow-to-output transfer strobe (used only with CFG_SHADOW_EN).
REQ-008 SHALL have port err_clr  input  1  clears bad_addr_err.
REQ-009 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  registered config outputs at addresses 0x00-0x04.
REQ-010 SHALL have port bad_addr_err  output  1  sticky flag, write to address above 0x04 seen.
REQ-011 SHALL have port wr_count  output  8  count of committed valid-address writes.

Function
REQ-012 a_ready/b_ready SHALL be combinational from valid inputs and last_grant; at most one high per cycle; ready never high without matching valid.
REQ-013 Only one valid high: that requester SHALL be granted the same cycle.
REQ-014 Both valid: requester not granted most recently SHALL be granted (round-robin); last_grant updates only on an accepted write.
REQ-015 Requesters SHALL hold addr/data stable while valid and not ready; a dropped valid before grant is a legal withdrawal.
REQ-016 Accepted write SHALL be captured into a one-entry commit stage (valid, addr, data) at acceptance edge N.
REQ-017 Commit stage SHALL update the target register at edge N+1; output visible after edge N+1; sustained throughput one write per cycle.
REQ-018 Back-to-back writes to the same address SHALL commit in acceptance order; last one wins.
REQ-019 Commit with address 0x05-0x7F SHALL discard data, set bad_addr_err at edge N+1, leave wr_count unchanged.
REQ-020 bad_addr_err SHALL stay 1 until err_clr; simultaneous set and err_clr SHALL leave it 1.
REQ-021 wr_count SHALL increment by 1 per committed valid-address write and wrap 0xFF -> 0x00.
REQ-022 Idle cycle (no commit) SHALL leave all outputs unchanged.

Reset
REQ-023 On rst_n low, all five config outputs, bad_addr_err and wr_count SHALL be 0x00/0 immediately.
REQ-024 Reset SHALL clear commit stage valid (pending write discarded), set last_grant to B so A wins first contention, and clear all shadow registers.
REQ-025 a_ready/b_ready SHALL be 0 while rst_n low.

Configuration
REQ-026 With CFG_SHADOW_EN defined, commits SHALL write five shadow registers; outputs SHALL load all shadows on an edge where apply=1.
REQ-027 With CFG_SHADOW_EN, commit and apply on the same edge SHALL deliver the committing value to the output on that edge.
REQ-028 Without CFG_SHADOW_EN, commits SHALL write outputs directly, no shadow storage, apply ignored.

Verification
REQ-029 A only: addr 0x04, data 0x80 -> a_ready same cycle, pwm_duty_cycle=0x80 one edge after accept, wr_count=1.
REQ-030 A and B valid 4 cycles, A addr 0x00 data 0x11, B addr 0x00 data 0x22 -> grants A,B,A,B; en_reg_out_7_0 ends 0x22.
REQ-031 B writes addr 0x07 data 0xFF -> no register change, bad_addr_err=1, wr_count unchanged; err_clr with concurrent bad write -> stays 1.
REQ-032 257 valid writes -> wr_count wraps to 0x01.
REQ-033 rst_n low on edge between accept and commit -> outputs 0x00, pending write lost, next contention grants A.
REQ-034 CFG_SHADOW_EN: write 0x03 data 0x5A, no apply -> en_reg_pwm_15_8 stays 0x00; apply -> 0x5A; commit+apply same edge -> new value visible that edge.
